// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: synchronizes and filters the PS/2 lines, frames
// 11-bit packets and emits one scan code per good frame as a one-cycle strobe.
module ps2_rx_deserializer #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       frame_error
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic [1:0]            clk_sync;
   logic [1:0]            dat_sync;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt_clk;
   logic                  fall;
   logic                  bit_in;

   logic [1:0]    state;
   logic [7:0]    shift_reg;
   logic [2:0]    bit_cnt;
   logic          parity_bit;
   logic [TW-1:0] timeout_cnt;

   // Idle bus is high, so synchronizers and filter reset to ones to avoid a false edge.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt_sr  <= '1;
         filt_clk <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
         filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
         if (filt_sr == '0)
            filt_clk <= 1'b0;
         else if (filt_sr == '1)
            filt_clk <= 1'b1;
      end
   end

   // Edge is seen combinationally so the strobe lands one edge after the filter settles.
   assign fall   = filt_clk && (filt_sr == '0);
   assign bit_in = dat_sync[1];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state            <= ST_IDLE;
         shift_reg        <= 8'h00;
         bit_cnt          <= 3'd0;
         parity_bit       <= 1'b0;
         timeout_cnt      <= '0;
         received_data    <= 8'h00;
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         frame_error      <= 1'b0;
      end else begin
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         frame_error      <= 1'b0;

         if (state != ST_IDLE) begin
            if (fall)
               timeout_cnt <= '0;
            else if (timeout_cnt == TIMEOUT_MAX) begin
               state       <= ST_IDLE;
               timeout_cnt <= '0;
            end else
               timeout_cnt <= timeout_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (fall && !bit_in) begin
                  shift_reg   <= 8'h00;
                  bit_cnt     <= 3'd0;
                  timeout_cnt <= '0;
                  state       <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (fall) begin
                  shift_reg <= {bit_in, shift_reg[7:1]};
                  if (bit_cnt == 3'd7)
                     state <= ST_PARITY;
                  else
                     bit_cnt <= bit_cnt + 3'd1;
               end
            end
            ST_PARITY: begin
               if (fall) begin
                  parity_bit <= bit_in;
                  state      <= ST_STOP;
               end
            end
            default: begin
               // A bad stop bit outranks parity so only one strobe ever fires.
               if (fall) begin
                  state <= ST_IDLE;
                  if (!bit_in)
                     frame_error <= 1'b1;
                  else if (^{shift_reg, parity_bit}) begin
                     received_data    <= shift_reg;
                     received_data_en <= 1'b1;
                  end else
                     parity_error <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/ps2_rx_deserializer.md
# ps2_rx_deserializer

Receive-only PS/2 device-to-host deserializer. It samples the keyboard's open-collector PS2_CLK/PS2_DAT lines, synchronizes and de-glitches them, checks each 11-bit frame, and emits one scan-code byte per valid frame as a single-cycle strobe. It sits directly upstream of the key-decode stage, which looks for F0 break prefixes and make codes (1D, 1B, 44, 75, 42, 72) and detects the rising edge of `received_data_en`.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal synchronized samples needed before the filtered PS2_CLK changes level (≥2).
- `TIMEOUT_CYCLES`, 50000: idle cycles between filtered PS2_CLK falling edges, inside a frame, that abort the frame (1 ms at 50 MHz).
- `CLOCK_50` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `PS2_CLK` input 1: raw PS/2 clock pin; asynchronous to CLOCK_50.
- `PS2_DAT` input 1: raw PS/2 data pin; asynchronous to CLOCK_50.
- `received_data` output 8: last good scan code; holds its value until the next good frame.
- `received_data_en` output 1: one-cycle strobe, high in the cycle `received_data` is updated.
- `parity_error` output 1: one-cycle strobe for a frame with bad odd parity.
- `frame_error` output 1: one-cycle strobe for a frame whose stop bit is 0.

## Operation
- **Synchronizers:** two-flop synchronizer on each pin. Both synchronizer chains reset to 1 (bus idle).
- **Clock filter:** shift register of `FILTER_LEN` synchronized PS2_CLK samples, reset to all-ones.
  - Filtered clock goes to 0 only when all samples are 0, and to 1 only when all samples are 1.
  - Otherwise it holds its previous level.
- **Edge detect:** `fall` is high for one cycle when the filtered clock changes 1→0.
- **Data sampling:** on `fall`, the synchronized PS2_DAT value is taken as the current bit.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on `fall` with bit 0 (start bit), clear the shift register, bit counter and timeout counter, then go to DATA. On `fall` with bit 1, stay in IDLE and report no error.
  - **DATA:** on `fall`, shift the bit in LSB-first (into bit 7, shifting right). Bit counter counts 0..7; after the 8th bit, go to PARITY.
  - **PARITY:** on `fall`, store the parity bit and go to STOP.
  - **STOP:** on `fall`, return to IDLE and evaluate the frame:
    - stop bit = 0: `frame_error` pulse only, whatever the parity.
    - stop bit = 1 and XOR of 8 data bits and parity bit = 1: update `received_data` and pulse `received_data_en`.
    - stop bit = 1 and XOR = 0: `parity_error` pulse only; `received_data` is unchanged.
- **Timeout:** in DATA, PARITY or STOP, the counter increments every cycle without `fall` and clears on every `fall`.
  - When it reaches `TIMEOUT_CYCLES - 1`, the FSM returns to IDLE.
  - A timeout produces no strobe and no error.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`; it saturates and cannot wrap.
- **Strobe exclusivity:** at most one of the three strobes is high in any cycle. Each strobe lasts exactly one cycle, even when the next start bit follows immediately.
- **Reset mid-frame:** the FSM returns to IDLE and the partial byte is discarded.

## Timing
- Reset values: `received_data` = 8'h00; `received_data_en`, `parity_error` and `frame_error` = 0; FSM = IDLE; all counters = 0.
- Latency: the strobe is registered and goes high on the clock edge after the cycle in which `fall` is detected for the stop bit.
  - From the first CLOCK_50 edge that samples PS2_CLK low, this is 2 (sync) + `FILTER_LEN` + 1 cycles.
  - `received_data` changes on the same edge as `received_data_en`.
- PS2_CLK low pulses shorter than `FILTER_LEN` cycles are ignored in every state.
- Minimum separation between consecutive `fall` events is 2·`FILTER_LEN` cycles. A PS/2 half-period (~30–50 µs) exceeds this by far.
- Data setup: PS2_DAT must be stable for 2 cycles before the filtered clock falls. The PS/2 protocol guarantees this by ≥5 µs.

## Test plan
- **Good frame:** bench PS/2 clock at 10 kHz (5000 cycles per bit); send 0x1D with parity 1 and stop 1 → exactly one `received_data_en` pulse, `received_data` = 8'h1D, no error strobes.
- **Break sequence:** send 0xF0 then 0x1D back-to-back, both with correct parity → two `received_data_en` pulses with data 8'hF0 then 8'h1D; each pulse is one cycle wide.
- **Parity error:** after a good 0x1D, send 0x75 with parity 1 (correct is 0) → one `parity_error` pulse, no `received_data_en`, `received_data` stays 8'h1D.
- **Framing error:** send 0x72 with correct parity 1 but stop 0 → one `frame_error` pulse only; then send a good 0x72 → `received_data` = 8'h72.
- **Timeout:** send start plus 3 data bits, then hold PS2_CLK high for 60000 cycles → no strobes. Then send a good 0x42 → `received_data` = 8'h42, with no bits left over from the aborted frame.
- **Glitch and reset:**
  - A 3-cycle low glitch on PS2_CLK in IDLE → no state change.
  - Assert `reset` for 1 cycle after 5 data bits of 0x44 → all outputs return to reset values; the following good 0x44 is received correctly.
